// File: rtl/wb_regfile_if.sv
// Write-back bundle carried from the MEM/WB pipeline register into the register file.
interface mem_stage_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rw_data;
    logic [4:0]  rw_addr;
    logic        rw_en;

    modport master (output pc, output inst, output rw_data, output rw_addr, output rw_en);
    modport slave  (input  pc, input  inst, input  rw_data, input  rw_addr, input  rw_en);
    modport i      (input  pc, input  inst, input  rw_data, input  rw_addr, input  rw_en);
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: general register file with write-first bypass on two read ports,
// retired-instruction counter and a one-cycle-delayed commit trace.
module wb_regfile #(
    parameter int REG_NUM = 32,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             rst,
    mem_stage_if.i           wb_info,
    input  logic [4:0]       ra1_addr,
    output logic [31:0]      ra1_data,
    input  logic [4:0]       ra2_addr,
    output logic [31:0]      ra2_data,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [31:0]      commit_inst,
    output logic             commit_wen,
    output logic [4:0]       commit_waddr,
    output logic [31:0]      commit_wdata,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam logic        RST_VALID    = 1'b1;
    localparam logic        EN_VALID     = 1'b1;
    localparam logic [31:0] ADDR_INVALID = 32'h0000_0000;

    logic [31:0]      rf_r [REG_NUM];
    logic             retire_s;
    logic             we_s;
    logic             commit_valid_r;
    logic [31:0]      commit_pc_r;
    logic [31:0]      commit_inst_r;
    logic             commit_wen_r;
    logic [4:0]       commit_waddr_r;
    logic [31:0]      commit_wdata_r;
    logic [CNT_W-1:0] retired_cnt_r;

    // Write-first read: x0 is constant zero, then the in-flight write, then storage.
    function automatic logic [31:0] read_sel(
        input logic [4:0]  addr,
        input logic        wen,
        input logic [4:0]  waddr,
        input logic [31:0] wdata,
        input logic [31:0] stored
    );
        logic [31:0] res;
        if (addr == 5'd0) begin
            res = 32'h0000_0000;
        end else if (wen && (waddr == addr)) begin
            res = wdata;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Retire and write qualifiers decoded from the incoming bundle.
    always_comb begin
        retire_s = 1'b0;
        we_s     = 1'b0;
        if (wb_info.pc != ADDR_INVALID) begin
            retire_s = 1'b1;
        end else begin
            retire_s = 1'b0;
        end
        if ((wb_info.rw_en == EN_VALID) && (wb_info.rw_addr != 5'd0)) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    // Combinational read ports for the decode stage.
    always_comb begin
        ra1_data = 32'h0000_0000;
        ra2_data = 32'h0000_0000;
        ra1_data = read_sel(ra1_addr, we_s, wb_info.rw_addr, wb_info.rw_data, rf_r[ra1_addr]);
        ra2_data = read_sel(ra2_addr, we_s, wb_info.rw_addr, wb_info.rw_data, rf_r[ra2_addr]);
    end

    // Register file, commit trace and retirement counter; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (rst == RST_VALID) begin
            for (int k = 0; k < REG_NUM; k++) begin
                rf_r[k] <= 32'h0000_0000;
            end
            commit_valid_r <= 1'b0;
            commit_pc_r    <= 32'h0000_0000;
            commit_inst_r  <= 32'h0000_0000;
            commit_wen_r   <= 1'b0;
            commit_waddr_r <= 5'd0;
            commit_wdata_r <= 32'h0000_0000;
            retired_cnt_r  <= {CNT_W{1'b0}};
        end else begin
            if (we_s) begin
                rf_r[wb_info.rw_addr] <= wb_info.rw_data;
            end
            commit_valid_r <= retire_s;
            commit_pc_r    <= wb_info.pc;
            commit_inst_r  <= wb_info.inst;
            commit_wen_r   <= we_s;
            commit_waddr_r <= wb_info.rw_addr;
            commit_wdata_r <= wb_info.rw_data;
            // Wraps naturally at 2^CNT_W.
            retired_cnt_r  <= retired_cnt_r + {{(CNT_W-1){1'b0}}, retire_s};
        end
    end

    assign commit_valid = commit_valid_r;
    assign commit_pc    = commit_pc_r;
    assign commit_inst  = commit_inst_r;
    assign commit_wen   = commit_wen_r;
    assign commit_waddr = commit_waddr_r;
    assign commit_wdata = commit_wdata_r;
    assign retired_cnt  = retired_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a full-width instance plus a CNT_W=4 instance for counter wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  ra1_addr;
    logic [4:0]  ra2_addr;
    logic [31:0] ra1_data;
    logic [31:0] ra2_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] commit_inst;
    logic        commit_wen;
    logic [4:0]  commit_waddr;
    logic [31:0] commit_wdata;
    logic [63:0] retired_cnt;

    logic [4:0]  w_ra1_addr;
    logic [4:0]  w_ra2_addr;
    logic [31:0] w_ra1_data;
    logic [31:0] w_ra2_data;
    logic        w_commit_valid;
    logic [31:0] w_commit_pc;
    logic [31:0] w_commit_inst;
    logic        w_commit_wen;
    logic [4:0]  w_commit_waddr;
    logic [31:0] w_commit_wdata;
    logic [3:0]  w_retired_cnt;

    int n_checks;
    int n_fail;

    mem_stage_if wb ();
    mem_stage_if wb2 ();

    wb_regfile #(.REG_NUM(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .wb_info(wb),
        .ra1_addr(ra1_addr), .ra1_data(ra1_data),
        .ra2_addr(ra2_addr), .ra2_data(ra2_data),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_wen(commit_wen), .commit_waddr(commit_waddr), .commit_wdata(commit_wdata),
        .retired_cnt(retired_cnt)
    );

    wb_regfile #(.REG_NUM(32), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .wb_info(wb2),
        .ra1_addr(w_ra1_addr), .ra1_data(w_ra1_data),
        .ra2_addr(w_ra2_addr), .ra2_data(w_ra2_data),
        .commit_valid(w_commit_valid), .commit_pc(w_commit_pc), .commit_inst(w_commit_inst),
        .commit_wen(w_commit_wen), .commit_waddr(w_commit_waddr), .commit_wdata(w_commit_wdata),
        .retired_cnt(w_retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled between edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic en,
                         input logic [4:0] addr, input logic [31:0] data);
        wb.pc      = pc;
        wb.inst    = inst;
        wb.rw_en   = en;
        wb.rw_addr = addr;
        wb.rw_data = data;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        ra1_addr   = 5'd5;
        ra2_addr   = 5'd0;
        w_ra1_addr = 5'd0;
        w_ra2_addr = 5'd0;
        wb2.pc = 32'h0; wb2.inst = 32'h0; wb2.rw_en = 1'b0; wb2.rw_addr = 5'd0; wb2.rw_data = 32'h0;
        drive(32'h1c00_0000, 32'h0000_0013, 1'b1, 5'd5, 32'hAAAA_5555);

        // Reset held two cycles with a live write on the bus.
        step();
        step();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("rst_x5", {32'h0, ra1_data}, 64'h0);
        check_eq("rst_cnt", retired_cnt, 64'h0);
        check_eq("rst_cvalid", {63'h0, commit_valid}, 64'h0);
        check_eq("rst_cpc", {32'h0, commit_pc}, 64'h0);

        // Write x3 with same-cycle bypass, then read from storage.
        drive(32'h1c00_0008, 32'h0000_0013, 1'b1, 5'd3, 32'hDEAD_BEEF);
        ra1_addr = 5'd3;
        #1;
        check_eq("byp_x3", {32'h0, ra1_data}, 64'hDEAD_BEEF);
        step();
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("rf_x3", {32'h0, ra1_data}, 64'hDEAD_BEEF);
        check_eq("x3_cwen", {63'h0, commit_wen}, 64'h1);
        check_eq("x3_cwaddr", {59'h0, commit_waddr}, 64'h3);
        check_eq("x3_cnt", retired_cnt, 64'h1);

        // Writes to x0 are dropped on both ports and in the trace.
        drive(32'h1c00_000c, 32'h0000_0013, 1'b1, 5'd0, 32'h1234_5678);
        ra1_addr = 5'd0;
        ra2_addr = 5'd0;
        #1;
        check_eq("r0_p1_now", {32'h0, ra1_data}, 64'h0);
        check_eq("r0_p2_now", {32'h0, ra2_data}, 64'h0);
        step();
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("r0_p1_next", {32'h0, ra1_data}, 64'h0);
        check_eq("r0_p2_next", {32'h0, ra2_data}, 64'h0);
        check_eq("r0_cwen", {63'h0, commit_wen}, 64'h0);
        check_eq("r0_cvalid", {63'h0, commit_valid}, 64'h1);

        // Back-to-back writes to x7 observed on both ports.
        ra1_addr = 5'd7;
        ra2_addr = 5'd7;
        drive(32'h1c00_0010, 32'h0000_0013, 1'b1, 5'd7, 32'h1);
        #1;
        check_eq("b2b_p1_1", {32'h0, ra1_data}, 64'h1);
        check_eq("b2b_p2_1", {32'h0, ra2_data}, 64'h1);
        step();
        drive(32'h1c00_0014, 32'h0000_0013, 1'b1, 5'd7, 32'h2);
        #1;
        check_eq("b2b_p1_2", {32'h0, ra1_data}, 64'h2);
        check_eq("b2b_p2_2", {32'h0, ra2_data}, 64'h2);
        step();
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("b2b_p1_hold", {32'h0, ra1_data}, 64'h2);
        check_eq("b2b_p2_hold", {32'h0, ra2_data}, 64'h2);
        check_eq("b2b_cnt", retired_cnt, 64'h4);

        // A bubble does not retire; the following instruction does.
        step();
        check_eq("bub_cnt", retired_cnt, 64'h4);
        check_eq("bub_cvalid", {63'h0, commit_valid}, 64'h0);
        drive(32'h1c00_0004, 32'h0280_0c21, 1'b1, 5'd1, 32'h3);
        step();
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("ret_cnt", retired_cnt, 64'h5);
        check_eq("ret_cvalid", {63'h0, commit_valid}, 64'h1);
        check_eq("ret_cpc", {32'h0, commit_pc}, 64'h1c00_0004);
        check_eq("ret_cinst", {32'h0, commit_inst}, 64'h0280_0c21);
        check_eq("ret_cwaddr", {59'h0, commit_waddr}, 64'h1);
        check_eq("ret_cwdata", {32'h0, commit_wdata}, 64'h3);
        step();
        check_eq("ret_cvalid_off", {63'h0, commit_valid}, 64'h0);
        check_eq("ret_cnt_hold", retired_cnt, 64'h5);

        // Narrow counter: fifteen retirements reach all-ones, the sixteenth wraps to zero.
        wb2.pc = 32'h1c00_0000;
        for (int i = 0; i < 15; i++) begin
            step();
        end
        check_eq("wrap_full", {60'h0, w_retired_cnt}, 64'hF);
        step();
        wb2.pc = 32'h0;
        #1;
        check_eq("wrap_zero", {60'h0, w_retired_cnt}, 64'h0);

        // Reset coinciding with a write to x9 leaves x9 cleared.
        ra1_addr = 5'd9;
        drive(32'h1c00_0018, 32'h0000_0013, 1'b1, 5'd9, 32'h1111_1111);
        step();
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("x9_pre", {32'h0, ra1_data}, 64'h1111_1111);
        rst = 1'b1;
        drive(32'h1c00_001c, 32'h0000_0013, 1'b1, 5'd9, 32'hCAFE_F00D);
        step();
        rst = 1'b0;
        drive(32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_eq("x9_post_rst", {32'h0, ra1_data}, 64'h0);
        check_eq("mid_rst_cnt", retired_cnt, 64'h0);
        check_eq("mid_rst_cvalid", {63'h0, commit_valid}, 64'h0);
        check_eq("mid_rst_cwdata", {32'h0, commit_wdata}, 64'h0);
        ra1_addr = 5'd7;
        #1;
        check_eq("x7_post_rst", {32'h0, ra1_data}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back end of the MEM/WB pipeline register. It consumes the registered write-back bundle, commits results into a 32×32-bit general register file, and serves two combinational read ports to the decode stage with same-cycle write bypass. It also keeps a retired-instruction counter and a one-cycle-delayed commit trace for difftest and debug.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hardwired to zero.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset (asserted level equals `RST_VALID`).
- wb_info  in  mem_stage_if.i  write-back bundle: pc[31:0], inst[31:0], rw_data[31:0], rw_addr[4:0], rw_en[0].
- ra1_addr  in  5  read port 1 address (decode stage).
- ra1_data  out  32  read port 1 data.
- ra2_addr  in  5  read port 2 address.
- ra2_data  out  32  read port 2 data.
- commit_valid  out  1  registered: an instruction retired in the previous cycle.
- commit_pc  out  32  registered pc of that instruction.
- commit_inst  out  32  registered instruction word.
- commit_wen  out  1  registered: the instruction wrote a register (address ≠ 0).
- commit_waddr  out  5  registered destination address.
- commit_wdata  out  32  registered write data.
- retired_cnt  out  CNT_W  registered count of retired instructions.

## Operation
- Retire condition: `retire = (wb_info.pc != `ADDR_INVALID`)`, where `ADDR_INVALID` is 32'h0. Bubbles from MEM/WB reset or flush carry `ADDR_INVALID` and do not retire.
- Write condition: `we = wb_info.rw_en == `EN_VALID` && wb_info.rw_addr != 0`. On the clock edge where `we` is true, `rf[rw_addr] <= rw_data`. A write is honoured even if `retire` is false; MEM/WB guarantees these never diverge.
- Register 0 always reads 0 and is never written.
- Read ports are combinational. For port n:
  - If `ranaddr == 0`, the port returns 0.
  - Otherwise, if `we && rw_addr == ranaddr`, the port returns `wb_info.rw_data` (write-first bypass).
  - Otherwise, the port returns `rf[ranaddr]`.
- Both read ports may name the same register. Both are bypassed identically.
- Commit trace registers load every cycle:
  - `commit_valid <= retire`
  - `commit_pc <= pc`
  - `commit_inst <= inst`
  - `commit_wen <= we`
  - `commit_waddr <= rw_addr`
  - `commit_wdata <= rw_data`
- When `retire` is false, the trace fields still load but `commit_valid` is 0.
- `retired_cnt <= retired_cnt + retire`. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (rst high at an edge): all `rf` entries, all `commit_*` outputs and `retired_cnt` become 0. While rst is held, no write, retire or count occurs, regardless of wb_info.
- Reset takes priority over a coincident write. The first write honoured is at the first edge where rst is low.
- Write latency: data presented in cycle N is in `rf` after edge N. Through the bypass it is visible on the read ports during cycle N itself, so a decode-stage read needs no extra stall for a WB-stage producer.
- Commit trace latency: exactly one cycle after the instruction is present on wb_info.
- `retired_cnt` reflects retirements up to and including the previous cycle.
- Back-to-back writes to the same register: the last write wins, and each write bypasses during its own cycle.
- No handshake is used. wb_info is assumed valid every cycle, and the block never stalls.

## Test plan
- Reset: hold rst for 2 cycles with wb_info driving pc=0x1c000000, rw_en=1, rw_addr=5, rw_data=0xAAAA5555. After release, expect ra1(5)=0, retired_cnt=0, commit_valid=0.
- Write then read: write x3=0xDEADBEEF at cycle N. Set ra1=3 in cycle N and expect the bypass value 0xDEADBEEF. In cycle N+1, with rw_en=0, expect ra1(3)=0xDEADBEEF from storage.
- r0 protection: write rw_addr=0, data=0x12345678. Expect ra1(0)=ra2(0)=0 in the same cycle and in the next. Expect commit_wen=0 and commit_valid=1 on the next cycle.
- Dual port and back-to-back writes: write x7=1, then x7=2 on consecutive cycles, with ra1=ra2=7. Expect both ports read 1 then 2, and 2 thereafter.
- Bubble versus retire: drive pc=0 (bubble), then pc=0x1c000004 with inst=0x02800c21, rw_en=1, rw_addr=1, data=0x3. Expect retired_cnt to increment by 1 only. The next cycle shows commit_valid=1, commit_pc=0x1c000004, commit_waddr=1, commit_wdata=0x3.
- Mid-stream reset and wrap: force retired_cnt to all-ones via a CNT_W=4 instance, retire once, and expect 0. Then assert rst during an active write to x9 and expect x9 to read 0 afterwards.
